// File: rtl/data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// data_memory_arbiter
//
// Gives one memory address/write port to two masters: the processor
// load/store path and a frame-transfer engine. The engine either streams a
// full IMAGE_WIDTH x IMAGE_HEIGHT frame into memory (load) or out of memory
// (dump). The memory has a combinational read and commits writes on the
// falling clock edge, so an access is one granted cycle.
//
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   c_req/c_we        processor request and write enable
//   c_addr/c_wdata    processor address and write data
//   c_gnt             processor access performed this cycle (combinational)
//   c_rdata/c_rvalid  registered read data and its one-cycle valid pulse
//   start/mode/base   launch a transfer (0 = load, 1 = dump) at frame base
//   busy/done         engine active / one-cycle completion pulse
//   s_valid/s_data    load stream input; s_ready marks a pixel accepted
//   d_valid/d_data    registered dump stream output; d_ready from consumer
//   M_WE/M_A/M_WD     memory port; M_RD is the memory read data
// ---------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int IMAGE_WIDTH  = 15,
    parameter int IMAGE_HEIGHT = 15,
    parameter int PIX_SIZE     = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                c_req,
    input  logic                c_we,
    input  logic [PIX_SIZE-1:0] c_addr,
    input  logic [PIX_SIZE-1:0] c_wdata,
    output logic                c_gnt,
    output logic [PIX_SIZE-1:0] c_rdata,
    output logic                c_rvalid,
    input  logic                start,
    input  logic                mode,
    input  logic [PIX_SIZE-1:0] base,
    output logic                busy,
    output logic                done,
    input  logic                s_valid,
    input  logic [PIX_SIZE-1:0] s_data,
    output logic                s_ready,
    output logic                d_valid,
    output logic [PIX_SIZE-1:0] d_data,
    input  logic                d_ready,
    output logic                M_WE,
    output logic [PIX_SIZE-1:0] M_A,
    output logic [PIX_SIZE-1:0] M_WD,
    input  logic [PIX_SIZE-1:0] M_RD
);

    localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [PIX_SIZE-1:0] LAST_IDX = PIX_SIZE'(NPIX - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DUMP,
        DRAIN,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [PIX_SIZE-1:0] base_r;
    logic [PIX_SIZE-1:0] idx;
    logic                prio_eng;   // 1: engine wins the next tie
    logic                ereq;
    logic                cgnt;
    logic                egnt;
    logic [PIX_SIZE-1:0] eaddr;

    // Engine request. In DUMP the output register must have room: either
    // it is empty or its word is being taken this cycle.
    always_comb begin
        ereq = 1'b0;
        case (state)
            LOAD:    ereq = s_valid;
            DUMP:    ereq = ~d_valid | d_ready;
            default: ereq = 1'b0;
        endcase
    end

    // Round-robin: on a tie the master not granted last wins.
    assign cgnt  = c_req & (~ereq | ~prio_eng);
    assign egnt  = ereq & ~cgnt;
    assign eaddr = base_r + idx;   // wraps at 2^PIX_SIZE

    assign c_gnt   = cgnt;
    assign s_ready = egnt & (state == LOAD);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_comb begin
        M_WE = 1'b0;
        M_A  = '0;
        M_WD = '0;
        if (cgnt) begin
            M_WE = c_we;
            M_A  = c_addr;
            M_WD = c_wdata;
        end else if (egnt) begin
            M_WE = (state == LOAD);
            M_A  = eaddr;
            M_WD = s_data;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = mode ? DUMP : LOAD;
                end
            end
            LOAD: begin
                if (egnt && (idx == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DUMP: begin
                if (egnt && (idx == LAST_IDX)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Last word must have left the output register.
                if (!d_valid || d_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            base_r   <= '0;
            idx      <= '0;
            prio_eng <= 1'b0;
            c_rdata  <= '0;
            c_rvalid <= 1'b0;
            d_valid  <= 1'b0;
            d_data   <= '0;
        end else begin
            if ((state == IDLE) && start) begin
                base_r <= base;
                idx    <= '0;
            end else if (egnt) begin
                idx <= idx + PIX_SIZE'(1);
            end

            if (cgnt) begin
                prio_eng <= 1'b1;
            end else if (egnt) begin
                prio_eng <= 1'b0;
            end

            c_rvalid <= cgnt & ~c_we;
            if (cgnt && !c_we) begin
                c_rdata <= M_RD;
            end

            if (egnt && (state == DUMP)) begin
                d_data  <= M_RD;
                d_valid <= 1'b1;
            end else if (d_valid && d_ready) begin
                d_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Drives data_memory_arbiter in front of a behavioural 64K x 16 memory and
// compares every cycle against a transaction-level model of the arbiter:
// round-robin grant rule, expected memory image, one-entry dump buffer and
// a pixel counter per transfer. Directed scenarios cover load, dump (with
// steady and toggling d_ready), CPU contention, address wrap, start while
// busy and reset mid-transfer; a randomized section mixes all traffic.
// ---------------------------------------------------------------------------
module tb_data_memory_arbiter;

    localparam int NPIX = 15 * 15;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DUMP  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        c_req, c_we;
    logic [15:0] c_addr, c_wdata;
    logic        c_gnt;
    logic [15:0] c_rdata;
    logic        c_rvalid;
    logic        start, mode;
    logic [15:0] base;
    logic        busy, done;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        d_valid;
    logic [15:0] d_data;
    logic        d_ready;
    logic        M_WE;
    logic [15:0] M_A, M_WD, M_RD;

    always #5 CLK = ~CLK;

    data_memory_arbiter #(
        .IMAGE_WIDTH (15),
        .IMAGE_HEIGHT(15),
        .PIX_SIZE    (16)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_gnt   (c_gnt),
        .c_rdata (c_rdata),
        .c_rvalid(c_rvalid),
        .start   (start),
        .mode    (mode),
        .base    (base),
        .busy    (busy),
        .done    (done),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .d_valid (d_valid),
        .d_data  (d_data),
        .d_ready (d_ready),
        .M_WE    (M_WE),
        .M_A     (M_A),
        .M_WD    (M_WD),
        .M_RD    (M_RD)
    );

    // Environment memory: combinational read, write on falling edge.
    logic [15:0] mem [0:65535];
    assign M_RD = mem[M_A];
    always @(negedge CLK) begin
        if (M_WE) mem[M_A] = M_WD;
    end

    // Reference model state
    logic [15:0] ref_mem [0:65535];
    int          ph;
    logic        cpu_last;
    logic [15:0] m_base;
    int          m_cnt;
    logic        m_rv;
    logic [15:0] m_rd;
    logic        m_dv;
    logic [15:0] m_dd;
    logic [15:0] ld_q[$];
    logic [15:0] rx_q[$];
    int          ndone;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus patterns
    int cpu_pat, sv_pat, dr_pat, sd_pat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph       = P_IDLE;
        cpu_last = 1'b0;
        m_base   = '0;
        m_cnt    = 0;
        m_rv     = 1'b0;
        m_rd     = '0;
        m_dv     = 1'b0;
        m_dd     = '0;
    endtask

    task automatic drive(input int cyc);
        case (cpu_pat)
            1: begin
                c_req   = 1'b1;
                c_we    = 1'b0;
                c_addr  = 16'h0005;
                c_wdata = 16'(0);
            end
            2: begin
                c_req   = 1'($urandom % 2);
                c_we    = 1'($urandom % 2);
                c_addr  = 16'(16'h0010 + ($urandom % 300));
                c_wdata = 16'($urandom);
            end
            default: begin
                c_req   = 1'b0;
                c_we    = 1'b0;
                c_addr  = 16'(0);
                c_wdata = 16'(0);
            end
        endcase
        s_valid = (sv_pat == 1) ? 1'($urandom % 2) : 1'b1;
        s_data  = (sd_pat == 1) ? 16'($urandom) : 16'(m_cnt);
        case (dr_pat)
            1:       d_ready = (cyc % 2 == 0);
            2:       d_ready = 1'($urandom % 2);
            default: d_ready = 1'b1;
        endcase
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model.
    task automatic step();
        logic        ew, cw, ewin, odv, xwe;
        logic [15:0] ea, xa, xwd;
        @(negedge CLK);
        ew   = (ph == P_LOAD) ? s_valid : (ph == P_DUMP) ? (!m_dv || d_ready) : 1'b0;
        cw   = c_req && (!ew || !cpu_last);
        ewin = ew && !cw;
        ea   = m_base + 16'(m_cnt);
        xwe  = 1'b0;
        xa   = '0;
        xwd  = '0;
        if (cw) begin
            xwe = c_we;
            xa  = c_addr;
            xwd = c_wdata;
        end else if (ewin) begin
            xwe = (ph == P_LOAD);
            xa  = ea;
            xwd = s_data;
        end
        check("c_gnt", c_gnt, cw);
        check("s_ready", s_ready, ewin && (ph == P_LOAD));
        check("M_WE", M_WE, xwe);
        check("M_A", M_A, xa);
        check("M_WD", M_WD, xwd);
        check("busy", busy, ph != P_IDLE);
        check("done", done, ph == P_DONE);
        check("c_rvalid", c_rvalid, m_rv);
        check("c_rdata", c_rdata, m_rd);
        check("d_valid", d_valid, m_dv);
        check("d_data", d_data, m_dd);

        if (d_valid && d_ready) rx_q.push_back(d_data);
        if (done) ndone++;

        odv = m_dv;
        m_rv = 1'b0;
        if (cw) begin
            cpu_last = 1'b1;
            if (c_we) begin
                ref_mem[c_addr] = c_wdata;
            end else begin
                m_rv = 1'b1;
                m_rd = ref_mem[c_addr];
            end
        end
        if (ewin) begin
            cpu_last = 1'b0;
            if (ph == P_LOAD) begin
                ref_mem[ea] = s_data;
                ld_q.push_back(s_data);
            end else begin
                m_dd = ref_mem[ea];
                m_dv = 1'b1;
            end
        end else if (odv && d_ready) begin
            m_dv = 1'b0;
        end
        case (ph)
            P_IDLE: begin
                if (start) begin
                    ph     = mode ? P_DUMP : P_LOAD;
                    m_base = base;
                    m_cnt  = 0;
                end
            end
            P_LOAD, P_DUMP: begin
                if (ewin) begin
                    m_cnt++;
                    if (m_cnt == NPIX) ph = (ph == P_LOAD) ? P_DONE : P_DRAIN;
                end
            end
            P_DRAIN: if (!odv || d_ready) ph = P_DONE;
            default: ph = P_IDLE;
        endcase
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            drive(i);
            step();
        end
    endtask

    // Launch a transfer and run until its done pulse; returns the cycle
    // (start cycle = 0) in which done was seen, or -1.
    task automatic run_xfer(input logic md, input logic [15:0] b, input int budget,
                            input int busy_start_at, output int done_cyc);
        int nd0;
        nd0      = ndone;
        done_cyc = -1;
        start = 1'b1;
        mode  = md;
        base  = b;
        drive(0);
        step();
        for (int c = 1; c <= budget; c++) begin
            if (busy_start_at > 0 && c >= busy_start_at && c < busy_start_at + 8) begin
                start = 1'b1;
                mode  = !md;
                base  = 16'h4000;
            end else begin
                start = 1'b0;
            end
            drive(c);
            step();
            if (ndone != nd0) begin
                done_cyc = c;
                break;
            end
        end
        start = 1'b0;
        check("xfer_done_seen", done_cyc >= 0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int nd0;
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A5A;
            ref_mem[i] = 16'(i) ^ 16'h5A5A;
        end
        ndone   = 0;
        cpu_pat = 0;
        sv_pat  = 0;
        dr_pat  = 0;
        sd_pat  = 0;
        start   = 1'b0;
        mode    = 1'b0;
        base    = '0;
        drive(0);
        model_reset();

        // Reset state
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_c_gnt", c_gnt, 1'b0);
        check("rst_c_rdata", c_rdata, 16'h0);
        check("rst_c_rvalid", c_rvalid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_d_data", d_data, 16'h0);
        check("rst_M_WE", M_WE, 1'b0);
        check("rst_M_A", M_A, 16'h0);
        check("rst_M_WD", M_WD, 16'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle(3);

        // Load 0..224 at 0x0010
        run_xfer(1'b0, 16'h0010, 400, 0, dc);
        check("load_done_cycle", dc, 226);
        idle(2);
        for (int k = 0; k < NPIX; k++) check("load_mem", mem[16'h0010 + k], k);

        // Dump, d_ready steady
        rx_q.delete();
        run_xfer(1'b1, 16'h0010, 400, 0, dc);
        idle(2);
        check("dump_rx_len", rx_q.size(), NPIX);
        for (int k = 0; k < NPIX && k < rx_q.size(); k++) check("dump_rx", rx_q[k], k);

        // Dump, d_ready toggling
        rx_q.delete();
        dr_pat = 1;
        run_xfer(1'b1, 16'h0010, 1000, 0, dc);
        idle(3);
        dr_pat = 0;
        check("dumpt_rx_len", rx_q.size(), NPIX);
        for (int k = 0; k < NPIX && k < rx_q.size(); k++) check("dumpt_rx", rx_q[k], k);

        // Contention: continuous CPU reads of 0x0005 during a load
        cpu_pat = 1;
        sd_pat  = 1;
        run_xfer(1'b0, 16'h0800, 1000, 0, dc);
        cpu_pat = 0;
        check("contend_done_cycle", dc, 450);
        idle(2);

        // Address wrap
        ld_q.delete();
        run_xfer(1'b0, 16'hFFF0, 400, 0, dc);
        idle(2);
        check("wrap_cnt", ld_q.size(), NPIX);
        for (int k = 0; k < NPIX && k < ld_q.size(); k++)
            check("wrap_mem", mem[16'(16'hFFF0 + k)], ld_q[k]);

        // start while busy, mode flipped
        nd0 = ndone;
        run_xfer(1'b0, 16'h0100, 400, 5, dc);
        idle(12);
        check("busy_start_done_cycle", dc, 226);
        check("busy_start_done_count", ndone - nd0, 1);

        // Reset in the middle of a load at idx 50
        nd0 = ndone;
        start = 1'b1;
        mode  = 1'b0;
        base  = 16'h0300;
        drive(0);
        step();
        start = 1'b0;
        for (int c = 1; c < 300 && m_cnt < 50; c++) begin
            drive(c);
            step();
        end
        check("midrst_idx", m_cnt, 50);
        RST = 1'b1;
        #2;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_M_WE", M_WE, 1'b0);
        model_reset();
        #1;
        RST = 1'b0;
        idle(3);
        check("midrst_no_done", ndone - nd0, 0);
        run_xfer(1'b0, 16'h0400, 400, 0, dc);
        check("midrst_reload_cycle", dc, 226);
        idle(2);

        // Randomized mixed traffic
        cpu_pat = 2;
        sv_pat  = 1;
        dr_pat  = 2;
        sd_pat  = 1;
        for (int t = 0; t < 4; t++) begin
            run_xfer(1'(t % 2), 16'(16'h0010 + ($urandom % 64)), 4000, 0, dc);
            idle(4);
        end
        cpu_pat = 0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
